// File: rtl/mrv1_imem_resp.sv
// Instruction-memory responder: word-addressed SRAM answering in-order fetches a fixed LATENCY_P cycles after accept.
// Optional access checking is enabled by defining MRV1_IMEM_ACCESS_CHK_EN.
module mrv1_imem_resp #(
   parameter int DEPTH_WORDS_P     = 1024,
   parameter int LATENCY_P         = 2,
   parameter int MAX_OUTSTANDING_P = 2,
   parameter int IDX_WIDTH_LP      = $clog2(DEPTH_WORDS_P)
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    imem_req_vld_i,
   output logic                    imem_req_rdy_o,
   input  logic [31:0]             imem_req_addr_i,
   output logic                    imem_resp_vld_o,
   output logic [31:0]             imem_resp_data_o,
   output logic                    imem_resp_err_o,
   input  logic                    load_we_i,
   input  logic [IDX_WIDTH_LP-1:0] load_addr_i,
   input  logic [31:0]             load_data_i
);

   localparam int CNT_W_LP = $clog2(MAX_OUTSTANDING_P + 1);

   logic [31:0]                 mem_q [DEPTH_WORDS_P];
   logic [31:0]                 rd_q;
   logic [LATENCY_P-1:0]        vld_q;
   logic [LATENCY_P-1:0]        err_q;
   logic [LATENCY_P-1:0][31:0]  stage_data;
   logic [CNT_W_LP-1:0]         cnt_q;
   logic [CNT_W_LP-1:0]         cnt_d;
   logic                        acc;
   logic                        acc_err;
   logic [IDX_WIDTH_LP-1:0]     acc_idx;
   logic                        unused_addr;

   assign imem_req_rdy_o = !rst_i &&
                           ((cnt_q < CNT_W_LP'(MAX_OUTSTANDING_P)) || imem_resp_vld_o);
   assign acc            = imem_req_vld_i & imem_req_rdy_o;
   assign acc_idx        = imem_req_addr_i[2 +: IDX_WIDTH_LP];
   assign unused_addr    = ^imem_req_addr_i;

`ifdef MRV1_IMEM_ACCESS_CHK_EN
   assign acc_err = (imem_req_addr_i[1:0] != 2'b00) ||
                    ({2'b00, imem_req_addr_i[31:2]} >= 32'(DEPTH_WORDS_P));
`else
   assign acc_err = 1'b0;
`endif

   // Read is taken at the accept edge, so a same-edge load write is not seen (read-first).
   always_ff @(posedge clk_i) begin
      if (load_we_i) begin
         mem_q[load_addr_i] <= load_data_i;
      end
      if (acc) begin
         rd_q <= mem_q[acc_idx];
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (acc && !imem_resp_vld_o) begin
         cnt_d = cnt_q + 1'b1;
      end else if (!acc && imem_resp_vld_o) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // err_q doubles as a zero-mask for data; it resets to 1 so the unreset SRAM read register never leaks out.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         vld_q <= '0;
         err_q <= '1;
         cnt_q <= '0;
      end else begin
         vld_q[0] <= acc;
         if (acc) begin
            err_q[0] <= acc_err;
         end
         for (int k = 1; k < LATENCY_P; k++) begin
            vld_q[k] <= vld_q[k-1];
            if (vld_q[k-1]) begin
               err_q[k] <= err_q[k-1];
            end
         end
         cnt_q <= cnt_d;
      end
   end

   assign stage_data[0] = rd_q;

   genvar gi;
   generate
      for (gi = 1; gi < LATENCY_P; gi++) begin : g_stage
         logic [31:0] d_q;
         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
               d_q <= '0;
            end else if (vld_q[gi-1]) begin
               d_q <= stage_data[gi-1];
            end
         end
         assign stage_data[gi] = d_q;
      end
   endgenerate

   assign imem_resp_vld_o  = vld_q[LATENCY_P-1];
   assign imem_resp_err_o  = vld_q[LATENCY_P-1] & err_q[LATENCY_P-1];
   assign imem_resp_data_o = err_q[LATENCY_P-1] ? 32'h0 : stage_data[LATENCY_P-1];

endmodule

// File: tb/tb_mrv1_imem_resp.sv
// Scoreboard bench for mrv1_imem_resp: default instance plus a MAX_OUTSTANDING_P=1 instance.
module tb_mrv1_imem_resp;

   localparam int LAT = 2;

   typedef struct {
      logic [31:0] data;
      logic        err;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   int          cyc = 0;
   int          tests = 0;
   int          fails = 0;

   logic        req_vld, req_vld1;
   logic [31:0] req_addr, req_addr1;
   logic        rdy0, rdy1;
   logic        rvld0, rvld1;
   logic [31:0] rdata0, rdata1;
   logic        rerr0, rerr1;
   logic        load_we;
   logic [9:0]  load_addr;
   logic [31:0] load_data;

   exp_t        q0[$];
   exp_t        q1[$];
   logic [31:0] last0 = 32'h0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mrv1_imem_resp u_dut0 (
      .clk_i(clk), .rst_i(rst),
      .imem_req_vld_i(req_vld), .imem_req_rdy_o(rdy0), .imem_req_addr_i(req_addr),
      .imem_resp_vld_o(rvld0), .imem_resp_data_o(rdata0), .imem_resp_err_o(rerr0),
      .load_we_i(load_we), .load_addr_i(load_addr), .load_data_i(load_data)
   );

   mrv1_imem_resp #(.MAX_OUTSTANDING_P(1)) u_dut1 (
      .clk_i(clk), .rst_i(rst),
      .imem_req_vld_i(req_vld1), .imem_req_rdy_o(rdy1), .imem_req_addr_i(req_addr1),
      .imem_resp_vld_o(rvld1), .imem_resp_data_o(rdata1), .imem_resp_err_o(rerr1),
      .load_we_i(load_we), .load_addr_i(load_addr), .load_data_i(load_data)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor for the default instance: ordering, data, err, latency and idle hold.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         last0 = 32'h0;
      end else if (rvld0) begin
         if (q0.size() == 0) begin
            chk("dut0_unexpected_resp", 32'd1, 32'd0);
         end else begin
            e = q0.pop_front();
            chk("dut0_data", rdata0, e.data);
            chk("dut0_err", {31'h0, rerr0}, {31'h0, e.err});
            chk("dut0_latency", cyc, e.cyc);
            $display("[TB] dut0 resp data=%h err=%0d cycle=%0d", rdata0, rerr0, cyc);
            last0 = e.data;
         end
      end else begin
         chk("dut0_idle_hold", rdata0, last0);
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (!rst && rvld1) begin
         if (q1.size() == 0) begin
            chk("dut1_unexpected_resp", 32'd1, 32'd0);
         end else begin
            e = q1.pop_front();
            chk("dut1_data", rdata1, e.data);
            chk("dut1_latency", cyc, e.cyc);
            $display("[TB] dut1 resp data=%h cycle=%0d", rdata1, cyc);
         end
      end
   end

   task automatic load(input logic [9:0] idx, input logic [31:0] d);
      load_we = 1'b1; load_addr = idx; load_data = d;
      @(posedge clk); #1;
      load_we = 1'b0;
   endtask

   // Leaves req_vld high so consecutive calls produce back-to-back requests.
   task automatic send0(input logic [31:0] a, input logic [31:0] d, input logic e, output int stalls);
      exp_t x;
      stalls = 0;
      req_vld = 1'b1; req_addr = a;
      @(negedge clk);
      while (!rdy0 && stalls < 20) begin
         stalls++;
         @(negedge clk);
      end
      if (!rdy0) begin
         chk("dut0_accept_timeout", {31'h0, rdy0}, 32'd1);
      end else begin
         x.data = d; x.err = e; x.cyc = cyc + LAT;
         q0.push_back(x);
      end
      @(posedge clk); #1;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while ((q0.size() != 0 || q1.size() != 0) && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk(name, q0.size() + q1.size(), 32'd0);
      q0.delete(); q1.delete();
      @(posedge clk); #1;
   endtask

   function automatic logic [31:0] word(input int i);
      return 32'hA000_0000 + 32'(i) * 32'h111;
   endfunction

   initial begin
      int st, total, k;
      exp_t x;
      rst = 1'b1; req_vld = 1'b0; req_addr = '0; req_vld1 = 1'b0; req_addr1 = '0;
      load_we = 1'b0; load_addr = '0; load_data = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_rdy", {31'h0, rdy0}, 32'd0);
      chk("reset_vld", {31'h0, rvld0}, 32'd0);
      chk("reset_err", {31'h0, rerr0}, 32'd0);
      chk("reset_data", rdata0, 32'h0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      chk("post_reset_rdy", {31'h0, rdy0}, 32'd1);

      // Single fetch
      load(10'd5, 32'h0050_0093);
      send0(32'h14, 32'h0050_0093, 1'b0, st);
      req_vld = 1'b0;
      drain("t1_drain");

      // Back-to-back burst of 8 with defaults: no stalls expected
      for (int i = 0; i < 8; i++) load(10'(i), word(i));
      total = 0;
      for (int i = 0; i < 8; i++) begin
         send0(32'(i * 4), word(i), 1'b0, st);
         total += st;
      end
      req_vld = 1'b0;
      chk("t2_burst_stalls", total, 32'd0);
      drain("t2_drain");

      // MAX_OUTSTANDING_P=1: ready alternates under continuous valid
      req_vld1 = 1'b1; k = 0;
      for (int i = 0; i < 8; i++) begin
         req_addr1 = 32'(k * 4);
         @(negedge clk);
         chk("t3_rdy_pattern", {31'h0, rdy1}, (i % 2 == 0) ? 32'd1 : 32'd0);
         if (rdy1) begin
            x.data = word(k); x.err = 1'b0; x.cyc = cyc + LAT;
            q1.push_back(x);
            k++;
         end
         @(posedge clk); #1;
      end
      req_vld1 = 1'b0;
      chk("t3_accepts", k, 32'd4);
      drain("t3_drain");

      // Same-cycle load and accept to one index returns old data
      load(10'd3, 32'hAAAA_0003);
      load_we = 1'b1; load_addr = 10'd3; load_data = 32'hBBBB_0003;
      send0(32'hC, 32'hAAAA_0003, 1'b0, st);
      load_we = 1'b0;
      send0(32'hC, 32'hBBBB_0003, 1'b0, st);
      req_vld = 1'b0;
      drain("t4_drain");

      // Asynchronous reset with requests in flight
      send0(32'h0, word(0), 1'b0, st);
      send0(32'h4, word(1), 1'b0, st);
      req_vld = 1'b0;
      #1 rst = 1'b1;
      q0.delete();
      #1;
      chk("t5_rst_vld", {31'h0, rvld0}, 32'd0);
      chk("t5_rst_err", {31'h0, rerr0}, 32'd0);
      chk("t5_rst_data", rdata0, 32'h0);
      chk("t5_rst_rdy", {31'h0, rdy0}, 32'd0);
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      chk("t5_rdy_after", {31'h0, rdy0}, 32'd1);
      chk("t5_cnt_after", 32'(u_dut0.cnt_q), 32'd0);

      // Out-of-range / misaligned addresses
      load(10'd1023, 32'hFFC0_FFC0);
`ifdef MRV1_IMEM_ACCESS_CHK_EN
      send0(32'h1002, 32'h0, 1'b1, st);
      send0(32'h1000, 32'h0, 1'b1, st);
`else
      send0(32'h1002, word(0), 1'b0, st);
      send0(32'h1000, word(0), 1'b0, st);
`endif
      send0(32'hFFC, 32'hFFC0_FFC0, 1'b0, st);
      req_vld = 1'b0;
      drain("t6_drain");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
